accel_mem_arbiter: RTL and testbench
====================================

# accel_mem_arbiter

Round-robin arbiter that shares the single accelerator memory port between up to `N` matrix engines (convolution, multiply, host loader). Each requester uses the standard engine memory handshake (`mem_operation` 01 read / 11 write / 00 none, held until `mem_opdone`). The arbiter sits between the engines and the SRAM/Wishbone bridge. It serialises whole transactions, enforces a gap cycle between them, and aborts hung transactions with a watchdog.

## Interface
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 255: cycles a granted transaction may wait for `mem_opdone` before abort (1..65535).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_op` in 2*N: per-requester operation; slice i = bits [2i+1:2i].
- `req_addr` in 32*N: per-requester word address.
- `req_wdata` in 32*N: per-requester write data.
- `req_rdata` out 32: read data, broadcast to all requesters (= `mem_rdata`, combinational).
- `req_opdone` out N: per-requester completion pulse.
- `mem_operation` out 2: downstream operation, registered.
- `mem_addr` out 32: downstream address, registered.
- `mem_wdata` out 32: downstream write data, registered.
- `mem_rdata` in 32: downstream read data, valid when `mem_opdone`=1.
- `mem_opdone` in 1: downstream completion, one-cycle pulse per transaction.
- `grant_id` out $clog2(N): index of the current or last granted requester.
- `busy` out 1: 1 while in GRANT.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- Two states: IDLE and GRANT. `ptr` is the last served index.
- **IDLE**
  - `mem_operation`=00.
  - If any `req_op[i]`≠00, select the first active i searching `ptr+1, ptr+2, …` modulo N.
  - Latch g=i into `grant_id`, load `mem_operation/mem_addr/mem_wdata` from slice g, clear the watchdog, go to GRANT.
- **GRANT**
  - Every cycle, the downstream registers reload from slice g (one-cycle tracking delay).
  - `req_opdone[g]` = `mem_opdone` (combinational). All other bits are 0.
- **Exits from GRANT**
  - On `mem_opdone`: `ptr`←g, `mem_operation`←00, go to IDLE. This guarantees a ≥1-cycle 00 gap between transactions, even when requester g keeps `req_op` asserted with a new address (parameter-fetch bursts). g then re-competes and loses to any other active requester.
  - If `req_op[g]` drops to 00 with no `mem_opdone`: requester abort. `ptr`←g, go to IDLE. No `req_opdone`.
  - Watchdog: counts GRANT cycles without `mem_opdone`. On reaching TIMEOUT, pulse `timeout_err`, drive `mem_operation`←00, `ptr`←g, go to IDLE. No `req_opdone` is issued; the requester keeps waiting and is re-granted later.
- `mem_opdone` in IDLE is ignored; no `req_opdone` bit rises.
- Watchdog counter width: 16 bits, saturating.

## Timing
- Reset values:
  - `mem_operation`=00, `mem_addr`=0, `mem_wdata`=0.
  - `grant_id`=0, `ptr`=N-1 (so index 0 wins first).
  - `busy`=0, `timeout_err`=0, state IDLE.
  - `req_opdone`=0 (gated by state).
- Grant latency: request seen in IDLE at edge k → `mem_operation` valid after edge k.
- Completion: `mem_opdone` at cycle c → `req_opdone[g]`=1 in cycle c. `mem_operation`=00 after edge c. Earliest next grant is visible after edge c+1.
- Simultaneous `mem_opdone` and `req_op[g]`→00 in the same cycle: treat as completion (pulse delivered).
- Simultaneous `mem_opdone` and watchdog expiry: completion wins, no `timeout_err`.
- `ptr` wraps N-1→0.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous). The in-flight transaction is lost.

## Test plan
- **Single reader:** only requester 2 drives op=01, addr=0x10; memory returns 0xDEADBEEF with `mem_opdone` 3 cycles after the grant → `mem_addr`=0x10, `req_opdone`=4'b0100 for one cycle, `req_rdata`=0xDEADBEEF, then `mem_operation`=00 for ≥1 cycle.
- **Round-robin fairness:** all 4 requesters hold op=01 continuously; memory completes each in 1 cycle → grant order after reset is 0,1,2,3,0,…; each grant is followed by a 00 gap cycle.
- **Burst requester:** requester 0 keeps op=01 while stepping addr 0→4; requester 1 issues a single write addr=0x20, data=0x5 → sequence is grant 0 (addr 0), grant 1 (write 0x20/0x5, `mem_operation`=11), then requester 0 resumes at addr 1.
- **Watchdog:** TIMEOUT=8, requester 3 granted, memory never responds → `timeout_err` pulses after 8 GRANT cycles, `mem_operation`=00, `req_opdone`=0. Requester 3 is re-granted after the other requesters.
- **Abort:** requester 1 drops op to 00 two cycles into its grant → `mem_operation`=00 one cycle later, no `req_opdone`, state IDLE.
- **Async reset:** pull `reset` low mid-GRANT between clock edges → `mem_operation`=00 and `busy`=0 before the next edge. After release, requester 0 is granted first.

Source files
------------

// File: rtl/accel_mem_arbiter.sv
// Round-robin arbiter serialising N engine memory transactions onto one port; grant is registered one edge after the request.
// Requesters simply wait while not granted; a 00 gap cycle follows every grant, and a watchdog aborts hung grants.
module accel_mem_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*N-1:0]       req_op,
  input  logic [32*N-1:0]      req_addr,
  input  logic [32*N-1:0]      req_wdata,
  output logic [31:0]          req_rdata,
  output logic [N-1:0]         req_opdone,
  output logic [1:0]           mem_operation,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_opdone,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int GW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [1:0]      mem_operation_q, mem_operation_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [15:0]     wdog_q, wdog_d;
  logic            timeout_err_q, timeout_err_d;

  logic [GW-1:0]   sel;
  logic            found;
  logic [1:0]      g_op;
  logic [31:0]     g_addr;
  logic [31:0]     g_wdata;
  logic            expire;

  assign g_op    = req_op[2*int'(grant_id_q) +: 2];
  assign g_addr  = req_addr[32*int'(grant_id_q) +: 32];
  assign g_wdata = req_wdata[32*int'(grant_id_q) +: 32];

  // Watchdog fires on the TIMEOUT-th consecutive GRANT cycle without completion.
  assign expire = ({1'b0, wdog_q} + 17'd1) >= 17'(TIMEOUT);

  // Round-robin search starting just after the last served index.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req_op[2*((int'(ptr_q) + k) % N) +: 2] != 2'b00) begin
        found = 1'b1;
        sel   = GW'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      ptr_q           <= GW'(N - 1);
      grant_id_q      <= '0;
      mem_operation_q <= 2'b00;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      wdog_q          <= '0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      grant_id_q      <= grant_id_d;
      mem_operation_q <= mem_operation_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      wdog_q          <= wdog_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    grant_id_d      = grant_id_q;
    mem_operation_d = mem_operation_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    wdog_d          = wdog_q;
    timeout_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        mem_operation_d = 2'b00;
        if (found) begin
          state_d         = GRANT;
          grant_id_d      = sel;
          mem_operation_d = req_op[2*int'(sel) +: 2];
          mem_addr_d      = req_addr[32*int'(sel) +: 32];
          mem_wdata_d     = req_wdata[32*int'(sel) +: 32];
          wdog_d          = '0;
        end
      end
      GRANT: begin
        mem_operation_d = g_op;
        mem_addr_d      = g_addr;
        mem_wdata_d     = g_wdata;
        wdog_d          = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
        // Completion outranks both requester abort and watchdog expiry.
        if (mem_opdone || g_op == 2'b00) begin
          state_d         = IDLE;
          ptr_d           = grant_id_q;
          mem_operation_d = 2'b00;
        end else if (expire) begin
          state_d         = IDLE;
          ptr_d           = grant_id_q;
          mem_operation_d = 2'b00;
          timeout_err_d   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    busy       = (state_q == GRANT);
    req_opdone = '0;
    if (state_q == GRANT && mem_opdone) begin
      req_opdone[grant_id_q] = 1'b1;
    end
  end

  assign req_rdata     = mem_rdata;
  assign mem_operation = mem_operation_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign grant_id      = grant_id_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Directed bench for accel_mem_arbiter: reset, single reader, round-robin, burst, watchdog, abort, async reset.
module tb_accel_mem_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [2*N-1:0]  req_op;
  logic [32*N-1:0] req_addr;
  logic [32*N-1:0] req_wdata;
  logic [31:0]    req_rdata;
  logic [N-1:0]   req_opdone;
  logic [1:0]     mem_operation;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [31:0]    mem_rdata;
  logic           mem_opdone;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  accel_mem_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_opdone(req_opdone),
    .mem_operation(mem_operation), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_opdone(mem_opdone),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    req_op[2*i +: 2]     = op;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req_op     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_opdone = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    req_op     = 8'b0101_0101;
    req_addr   = '1;
    req_wdata  = '1;
    mem_opdone = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    checks++; if (mem_operation !== 2'b00) begin errors++; $display("FAIL reset_op got %h want 0", mem_operation); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %b want 0", timeout_err); end
    mem_opdone = 1'b1;
    #1;
    checks++; if (req_opdone !== 4'b0000) begin errors++; $display("FAIL reset_opdone got %b want 0000", req_opdone); end
    mem_opdone = 1'b0;
    req_op = '0;
    reset  = 1'b1;
    tick();
  endtask

  task automatic test_single_reader();
    set_req(2, 2'b01, 32'h10, 32'h0);
    tick();
    checks++; if (mem_operation !== 2'b01) begin errors++; $display("FAIL single_op got %h want 1", mem_operation); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL single_addr got %h want 10", mem_addr); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant got %0d want 2", grant_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    tick();
    checks++; if (req_opdone !== 4'b0000) begin errors++; $display("FAIL single_early_done got %b want 0000", req_opdone); end
    tick();
    mem_rdata  = 32'hDEADBEEF;
    mem_opdone = 1'b1;
    #1;
    checks++; if (req_opdone !== 4'b0100) begin errors++; $display("FAIL single_done got %b want 0100", req_opdone); end
    checks++; if (req_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %h want deadbeef", req_rdata); end
    tick();
    mem_opdone = 1'b0;
    set_req(2, 2'b00, 32'h0, 32'h0);
    #1;
    checks++; if (mem_operation !== 2'b00) begin errors++; $display("FAIL single_gap got %h want 0", mem_operation); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", busy); end
    checks++; if (req_opdone !== 4'b0000) begin errors++; $display("FAIL single_done_clear got %b want 0000", req_opdone); end
  endtask

  task automatic test_round_robin();
    int exp_g;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'b01, 32'h100 + 32'(i), 32'h0);
    for (int r = 0; r < 6; r++) begin
      exp_g = r % N;
      tick();
      checks++; if (grant_id !== 2'(exp_g)) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", r, grant_id, exp_g); end
      checks++; if (mem_addr !== 32'h100 + 32'(exp_g)) begin errors++; $display("FAIL rr_addr[%0d] got %h want %h", r, mem_addr, 32'h100 + 32'(exp_g)); end
      mem_opdone = 1'b1;
      #1;
      checks++; if (req_opdone !== 4'(1 << exp_g)) begin errors++; $display("FAIL rr_done[%0d] got %b want %b", r, req_opdone, 4'(1 << exp_g)); end
      tick();
      mem_opdone = 1'b0;
      checks++; if (mem_operation !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d] got op %h busy %b want 0 0", r, mem_operation, busy); end
    end
    req_op = '0;
  endtask

  task automatic test_burst();
    do_reset();
    set_req(0, 2'b01, 32'h0, 32'h0);
    set_req(1, 2'b11, 32'h20, 32'h5);
    tick();
    checks++; if (grant_id !== 2'd0 || mem_addr !== 32'h0 || mem_operation !== 2'b01) begin errors++; $display("FAIL burst_g0 got g%0d a%h op%h want g0 a0 op1", grant_id, mem_addr, mem_operation); end
    mem_opdone = 1'b1;
    tick();
    mem_opdone = 1'b0;
    set_req(0, 2'b01, 32'h1, 32'h0);
    checks++; if (mem_operation !== 2'b00) begin errors++; $display("FAIL burst_gap got %h want 0", mem_operation); end
    tick();
    checks++; if (grant_id !== 2'd1 || mem_operation !== 2'b11) begin errors++; $display("FAIL burst_g1 got g%0d op%h want g1 op3", grant_id, mem_operation); end
    checks++; if (mem_addr !== 32'h20 || mem_wdata !== 32'h5) begin errors++; $display("FAIL burst_wr got a%h d%h want a20 d5", mem_addr, mem_wdata); end
    mem_opdone = 1'b1;
    tick();
    mem_opdone = 1'b0;
    set_req(1, 2'b00, 32'h0, 32'h0);
    tick();
    checks++; if (grant_id !== 2'd0 || mem_addr !== 32'h1) begin errors++; $display("FAIL burst_resume got g%0d a%h want g0 a1", grant_id, mem_addr); end
    mem_opdone = 1'b1;
    tick();
    mem_opdone = 1'b0;
    req_op = '0;
  endtask

  task automatic test_watchdog();
    do_reset();
    set_req(3, 2'b01, 32'h300, 32'h0);
    tick();
    checks++; if (grant_id !== 2'd3 || busy !== 1'b1) begin errors++; $display("FAIL wd_grant got g%0d busy%b want g3 busy1", grant_id, busy); end
    repeat (TO - 1) tick();
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL wd_early got busy%b tmo%b want 1 0", busy, timeout_err); end
    set_req(0, 2'b01, 32'h100, 32'h0);
    set_req(1, 2'b01, 32'h110, 32'h0);
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_pulse got %b want 1", timeout_err); end
    checks++; if (mem_operation !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL wd_abort got op%h busy%b want 0 0", mem_operation, busy); end
    checks++; if (req_opdone !== 4'b0000) begin errors++; $display("FAIL wd_nodone got %b want 0000", req_opdone); end
    tick();
    checks++; if (timeout_err !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL wd_next got tmo%b g%0d want 0 g0", timeout_err, grant_id); end
    mem_opdone = 1'b1;
    tick();
    mem_opdone = 1'b0;
    set_req(0, 2'b00, 32'h0, 32'h0);
    tick();
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL wd_g1 got %0d want 1", grant_id); end
    mem_opdone = 1'b1;
    tick();
    mem_opdone = 1'b0;
    set_req(1, 2'b00, 32'h0, 32'h0);
    tick();
    checks++; if (grant_id !== 2'd3 || mem_addr !== 32'h300) begin errors++; $display("FAIL wd_regrant got g%0d a%h want g3 a300", grant_id, mem_addr); end
    mem_opdone = 1'b1;
    #1;
    checks++; if (req_opdone !== 4'b1000) begin errors++; $display("FAIL wd_done got %b want 1000", req_opdone); end
    tick();
    mem_opdone = 1'b0;
    req_op = '0;
  endtask

  task automatic test_abort();
    set_req(1, 2'b01, 32'h30, 32'h0);
    tick();
    checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL abort_grant got g%0d busy%b want g1 busy1", grant_id, busy); end
    tick();
    set_req(1, 2'b00, 32'h30, 32'h0);
    #1;
    checks++; if (req_opdone !== 4'b0000) begin errors++; $display("FAIL abort_nodone got %b want 0000", req_opdone); end
    tick();
    checks++; if (mem_operation !== 2'b00 || busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL abort_idle got op%h busy%b tmo%b want 0 0 0", mem_operation, busy, timeout_err); end
    mem_opdone = 1'b1;
    #1;
    checks++; if (req_opdone !== 4'b0000) begin errors++; $display("FAIL idle_done got %b want 0000", req_opdone); end
    tick();
    mem_opdone = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_done_busy got %b want 0", busy); end
    set_req(2, 2'b01, 32'h40, 32'h0);
    tick();
    set_req(2, 2'b00, 32'h40, 32'h0);
    mem_opdone = 1'b1;
    #1;
    checks++; if (req_opdone !== 4'b0100) begin errors++; $display("FAIL drop_done got %b want 0100", req_opdone); end
    tick();
    mem_opdone = 1'b0;
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL drop_idle got busy%b tmo%b want 0 0", busy, timeout_err); end
  endtask

  task automatic test_async_reset();
    set_req(2, 2'b01, 32'h50, 32'h7);
    tick();
    checks++; if (busy !== 1'b1 || mem_operation !== 2'b01) begin errors++; $display("FAIL ar_grant got busy%b op%h want 1 1", busy, mem_operation); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (mem_operation !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL ar_clear got op%h busy%b want 0 0", mem_operation, busy); end
    checks++; if (mem_addr !== 32'h0 || grant_id !== 2'd0) begin errors++; $display("FAIL ar_regs got a%h g%0d want 0 0", mem_addr, grant_id); end
    req_op = 8'b0101_0101;
    #1;
    reset = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL ar_first got g%0d busy%b want g0 busy1", grant_id, busy); end
    req_op = '0;
    mem_opdone = 1'b1;
    tick();
    mem_opdone = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_reader();
    test_round_robin();
    test_burst();
    test_watchdog();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
